// File: rtl/veggie_field_engine_if.sv
// rtl/veggie_field_engine_if.sv - video timing, katana position and per-slot sprite bus of the veggie field engine
interface veggie_field_engine_if #(
  parameter int NUM_VEGGIES = 4
);
  logic [10:0]               hcount_in;
  logic [9:0]                vcount_in;
  logic [10:0]               katana_x;
  logic [9:0]                katana_y;
  logic [11*NUM_VEGGIES-1:0] veggie_x_out;
  logic [10*NUM_VEGGIES-1:0] veggie_y_out;
  logic [NUM_VEGGIES-1:0]    veggie_active_out;
  logic [NUM_VEGGIES-1:0]    veggie_split_out;
  logic [NUM_VEGGIES-1:0]    split_pulse_out;
  logic [15:0]               score_out;
  logic [7:0]                miss_out;

  modport master (
    output hcount_in, vcount_in, katana_x, katana_y,
    input  veggie_x_out, veggie_y_out, veggie_active_out, veggie_split_out,
    input  split_pulse_out, score_out, miss_out
  );

  modport slave (
    input  hcount_in, vcount_in, katana_x, katana_y,
    output veggie_x_out, veggie_y_out, veggie_active_out, veggie_split_out,
    output split_pulse_out, score_out, miss_out
  );
endinterface

// File: rtl/veggie_field_engine.sv
// rtl/veggie_field_engine.sv - per-frame physics, katana hit detection and scoring for NUM_VEGGIES slots
module veggie_field_engine #(
  parameter int          NUM_VEGGIES    = 4,
  parameter int          SCREEN_W       = 1024,
  parameter int          SCREEN_H       = 768,
  parameter int          VEG_W          = 64,
  parameter int          VEG_H          = 64,
  parameter int          GRAVITY        = 1,
  parameter int          LAUNCH_VY_MIN  = 12,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  veggie_field_engine_if.slave bus
);

  localparam int                X_MAX       = SCREEN_W - VEG_W;
  localparam int                Y_LAUNCH    = SCREEN_H - VEG_H;
  localparam logic signed [11:0] X_MAX_S    = 12'(X_MAX);
  localparam logic signed [11:0] Y_EXIT_S   = 12'(Y_LAUNCH);
  localparam logic signed [7:0]  GRAV_S     = 8'(GRAVITY);
  localparam logic signed [7:0]  VY_SAT_LIM = 8'(127 - GRAVITY);
  localparam logic [15:0]        RESPAWN_CNT = 16'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLYING,
    S_SPLIT
  } slot_state_e;

  slot_state_e        state_q [NUM_VEGGIES];
  slot_state_e        state_d [NUM_VEGGIES];
  logic [15:0]        cnt_q   [NUM_VEGGIES];
  logic [15:0]        cnt_d   [NUM_VEGGIES];
  logic [10:0]        x_q     [NUM_VEGGIES];
  logic [10:0]        x_d     [NUM_VEGGIES];
  logic [9:0]         y_q     [NUM_VEGGIES];
  logic [9:0]         y_d     [NUM_VEGGIES];
  logic signed [3:0]  vx_q    [NUM_VEGGIES];
  logic signed [3:0]  vx_d    [NUM_VEGGIES];
  logic signed [7:0]  vy_q    [NUM_VEGGIES];
  logic signed [7:0]  vy_d    [NUM_VEGGIES];

  logic [15:0]            lfsr_q, lfsr_d;
  logic [15:0]            score_q, score_d;
  logic [7:0]             miss_q, miss_d;
  logic [NUM_VEGGIES-1:0] pulse_q, pulse_d;

  logic                   frame_done;
  logic signed [11:0]     nx, ny;
  logic signed [3:0]      nvx;
  logic signed [7:0]      nvy;
  logic                   hit, exit_now;
  logic [9:0]             rl;
  logic [3:0]             hit_cnt, miss_cnt;
  logic [16:0]            score_sum;
  logic [8:0]             miss_sum;

  assign frame_done = (bus.hcount_in == 11'(SCREEN_W)) && (bus.vcount_in == 10'(SCREEN_H));

  // Each slot sees the shared LFSR rotated right by 3*slot so simultaneous launches differ.
  function automatic logic [9:0] slot_lfsr(input logic [15:0] l, input int slot);
    logic [31:0] dbl;
    int          s;
    s   = (3 * slot) % 16;
    dbl = {l, l};
    return 10'(dbl >> s);
  endfunction

  always_comb begin
    lfsr_d   = lfsr_q;
    pulse_d  = '0;
    hit_cnt  = '0;
    miss_cnt = '0;
    nx       = '0;
    ny       = '0;
    nvx      = '0;
    nvy      = '0;
    hit      = 1'b0;
    exit_now = 1'b0;
    rl       = '0;
    for (int i = 0; i < NUM_VEGGIES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
      vx_d[i]    = vx_q[i];
      vy_d[i]    = vy_q[i];

      rl  = slot_lfsr(lfsr_q, i);
      nx  = $signed({1'b0, x_q[i]}) + 12'(vx_q[i]);
      nvx = vx_q[i];
      if (nx < 12'sd0) begin
        nx  = '0;
        nvx = -vx_q[i];
      end else if (nx > X_MAX_S) begin
        nx  = X_MAX_S;
        nvx = -vx_q[i];
      end
      ny  = $signed({2'b0, y_q[i]}) + 12'(vy_q[i]);
      nvy = vy_q[i];
      if (ny < 12'sd0) begin
        ny  = '0;
        nvy = '0;
      end
      nvy      = (nvy > VY_SAT_LIM) ? 8'sd127 : nvy + GRAV_S;
      exit_now = (ny >= Y_EXIT_S) && (nvy > 8'sd0);

      // Hit test uses the coordinates on screen this frame, before the motion update.
      hit = (state_q[i] == S_FLYING)
         && ({1'b0, bus.katana_x} >= {1'b0, x_q[i]})
         && ({1'b0, bus.katana_x} <  {1'b0, x_q[i]} + 12'(VEG_W))
         && ({1'b0, bus.katana_y} >= {1'b0, y_q[i]})
         && ({1'b0, bus.katana_y} <  {1'b0, y_q[i]} + 11'(VEG_H));

      if (frame_done) begin
        case (state_q[i])
          S_IDLE: begin
            if (cnt_q[i] <= 16'd1) begin
              state_d[i] = S_FLYING;
              cnt_d[i]   = '0;
              x_d[i]     = 11'(32'(rl) % X_MAX);
              y_d[i]     = 10'(Y_LAUNCH);
              vy_d[i]    = -(8'(LAUNCH_VY_MIN) + {4'b0, rl[3:0]});
              vx_d[i]    = 4'({1'b0, rl[6:4]}) - 4'd3;
            end else begin
              cnt_d[i] = cnt_q[i] - 16'd1;
            end
          end
          S_FLYING, S_SPLIT: begin
            x_d[i]  = 11'(nx);
            y_d[i]  = 10'(ny);
            vx_d[i] = nvx;
            vy_d[i] = nvy;
            if (hit) begin
              pulse_d[i] = 1'b1;
              hit_cnt    = hit_cnt + 4'd1;
              if (exit_now) begin
                state_d[i] = S_IDLE;
                cnt_d[i]   = RESPAWN_CNT;
              end else begin
                state_d[i] = S_SPLIT;
                vx_d[i]    = '0;
              end
            end else if (exit_now) begin
              if (state_q[i] == S_FLYING) begin
                miss_cnt = miss_cnt + 4'd1;
              end
              state_d[i] = S_IDLE;
              cnt_d[i]   = RESPAWN_CNT;
            end
          end
          default: state_d[i] = S_IDLE;
        endcase
      end
    end

    if (frame_done) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    score_sum = {1'b0, score_q} + 17'(hit_cnt);
    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    miss_sum  = {1'b0, miss_q} + 9'(miss_cnt);
    miss_d    = miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
      miss_q  <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_VEGGIES; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= 16'(RESPAWN_FRAMES * (i + 1));
        x_q[i]     <= '0;
        y_q[i]     <= '0;
        vx_q[i]    <= '0;
        vy_q[i]    <= '0;
      end
    end else begin
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NUM_VEGGIES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        vx_q[i]    <= vx_d[i];
        vy_q[i]    <= vy_d[i];
      end
    end
  end

  always_comb begin
    bus.veggie_x_out      = '0;
    bus.veggie_y_out      = '0;
    bus.veggie_active_out = '0;
    bus.veggie_split_out  = '0;
    for (int i = 0; i < NUM_VEGGIES; i++) begin
      bus.veggie_x_out[11*i +: 11] = x_q[i];
      bus.veggie_y_out[10*i +: 10] = y_q[i];
      bus.veggie_active_out[i]     = (state_q[i] != S_IDLE);
      bus.veggie_split_out[i]      = (state_q[i] == S_SPLIT);
    end
  end

  assign bus.split_pulse_out = pulse_q;
  assign bus.score_out       = score_q;
  assign bus.miss_out        = miss_q;

endmodule

// File: tb/tb_veggie_field_engine.sv
// tb/tb_veggie_field_engine.sv - directed stimulus with a frame-level behavioural model for veggie_field_engine
`timescale 1ns/1ps
module tb_veggie_field_engine;
  localparam int NV = 4;
  localparam int FAR_X = 2000;
  localparam int FAR_Y = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  veggie_field_engine_if #(.NUM_VEGGIES(NV)) bus ();

  veggie_field_engine #(.NUM_VEGGIES(NV)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 = idle, 1 = flying, 2 = split.
  int      m_state [NV];
  int      m_cnt   [NV];
  int      m_x     [NV];
  int      m_y     [NV];
  int      m_vx    [NV];
  int      m_vy    [NV];
  int      m_lfsr, m_score, m_miss, m_raw_miss;
  bit [NV-1:0] m_pulse;
  bit      chk_en = 1'b0;
  int      kx = FAR_X;
  int      ky = FAR_Y;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rotr(int v, int s);
    return ((v >> s) | (v << (16 - s))) & 'hFFFF;
  endfunction

  function automatic int lfsr_next(int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 'hFFFF;
  endfunction

  function automatic void move(inout int x, inout int y, inout int vx, inout int vy);
    x = x + vx;
    if (x < 0) begin
      x = 0;
      vx = -vx;
    end else if (x > 960) begin
      x = 960;
      vx = -vx;
    end
    y = y + vy;
    if (y < 0) begin
      y = 0;
      vy = 0;
    end
    vy = (vy + 1 > 127) ? 127 : vy + 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_state[i] = 0;
      m_cnt[i]   = 60 * (i + 1);
      m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
    end
    m_lfsr = 'hACE1; m_score = 0; m_miss = 0; m_pulse = '0;
  endfunction

  function automatic void model_frame();
    bit [NV-1:0] p;
    int r;
    bit hit, gone;
    p = '0;
    for (int i = 0; i < NV; i++) begin
      r = rotr(m_lfsr, (3 * i) % 16);
      if (m_state[i] == 0) begin
        m_cnt[i] = m_cnt[i] - 1;
        if (m_cnt[i] == 0) begin
          m_state[i] = 1;
          m_x[i]  = (r & 1023) % 960;
          m_y[i]  = 704;
          m_vy[i] = -(12 + (r & 15));
          m_vx[i] = ((r >> 4) & 7) - 3;
        end
      end else begin
        hit = (m_state[i] == 1) && kx >= m_x[i] && kx < m_x[i] + 64
              && ky >= m_y[i] && ky < m_y[i] + 64;
        move(m_x[i], m_y[i], m_vx[i], m_vy[i]);
        gone = (m_y[i] >= 704) && (m_vy[i] > 0);
        if (hit) begin
          p[i] = 1'b1;
          m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
          if (gone) begin
            m_state[i] = 0; m_cnt[i] = 60;
          end else begin
            m_state[i] = 2; m_vx[i] = 0;
          end
        end else if (gone) begin
          if (m_state[i] == 1) begin
            m_raw_miss++;
            m_miss = (m_miss + 1 > 255) ? 255 : m_miss + 1;
          end
          m_state[i] = 0; m_cnt[i] = 60;
        end
      end
    end
    m_lfsr  = lfsr_next(m_lfsr);
    m_pulse = p;
  endfunction

  task automatic tick(input bit fd);
    bus.hcount_in = fd ? 11'd1024 : 11'd0;
    bus.vcount_in = fd ? 10'd768 : 10'd0;
    bus.katana_x  = 11'(kx);
    bus.katana_y  = 10'(ky);
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else if (fd) model_frame();
    else m_pulse = '0;
  endtask

  task automatic frame();
    tick(1'b1);
    tick(1'b0);
  endtask

  logic [11*NV-1:0] ex_x;
  logic [10*NV-1:0] ex_y;
  logic [NV-1:0]    ex_act, ex_spl;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NV; i++) begin
        ex_x[11*i +: 11] = 11'(m_x[i]);
        ex_y[10*i +: 10] = 10'(m_y[i]);
        ex_act[i] = (m_state[i] != 0);
        ex_spl[i] = (m_state[i] == 2);
      end
      check("x_out", bus.veggie_x_out, ex_x);
      check("y_out", bus.veggie_y_out, ex_y);
      check("active_out", bus.veggie_active_out, ex_act);
      check("split_out", bus.veggie_split_out, ex_spl);
      check("pulse_out", bus.split_pulse_out, m_pulse);
      check("score_out", bus.score_out, 64'(m_score));
      check("miss_out", bus.miss_out, 64'(m_miss));
    end
  end

  initial begin
    int x, y, vx, vy, n, cx, cy, k, s_before, miss_mark;
    bit found;
    m_raw_miss = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) tick(1'b0);
    chk_en = 1'b1;
    check("rst_score", bus.score_out, 0);
    check("rst_miss", bus.miss_out, 0);
    check("rst_active", bus.veggie_active_out, 0);
    check("rst_split", bus.veggie_split_out, 0);
    check("rst_pulse", bus.split_pulse_out, 0);
    check("rst_x", bus.veggie_x_out, 0);
    rst = 1'b0;

    check("pin_lfsr_1", lfsr_next('hACE1), 'h59C3);
    check("pin_lfsr_2", lfsr_next('h59C3), 'hB387);
    check("pin_rotr", rotr(1, 3), 'h2000);
    x = 958; y = 300; vx = 4; vy = 0;
    move(x, y, vx, vy);
    check("pin_wall_right_x", x, 960);
    check("pin_wall_right_vx", vx, -4);
    x = 2; vx = -3; y = 5; vy = -10;
    move(x, y, vx, vy);
    check("pin_wall_left_x", x, 0);
    check("pin_wall_left_vx", vx, 3);
    check("pin_top_y", y, 0);
    check("pin_top_vy", vy, 1);
    x = 100; y = 704; vx = 0; vy = -12;
    repeat (12) move(x, y, vx, vy);
    check("pin_traj_peak_y", y, 626);
    check("pin_traj_peak_vy", vy, 0);
    n = 0;
    while (!(y >= 704 && vy > 0) && n < 100) begin
      move(x, y, vx, vy);
      n++;
    end
    check("pin_traj_fall_frames", n, 13);
    check("pin_traj_exit_y", y, 704);

    for (int f = 1; f <= 60; f++) begin
      if (f == 60) check("slot0_idle_after_59", bus.veggie_active_out[0], 0);
      frame();
      if (f == 1) check("model_lfsr_after_1", m_lfsr, 'h59C3);
    end
    check("slot0_active_after_60", bus.veggie_active_out[0], 1);

    kx = m_x[0] + 10; ky = m_y[0] + 10;
    tick(1'b1);
    check("hit_split", bus.veggie_split_out[0], 1);
    check("hit_pulse", bus.split_pulse_out[0], 1);
    check("hit_score", bus.score_out, 1);
    tick(1'b0);
    check("hit_pulse_gone", bus.split_pulse_out, 0);
    kx = m_x[0] + 10; ky = m_y[0] + 10;
    tick(1'b1);
    check("rehit_score", bus.score_out, 1);
    check("rehit_pulse", bus.split_pulse_out, 0);
    tick(1'b0);
    kx = FAR_X; ky = FAR_Y;
    n = 0;
    while (bus.veggie_active_out[0] && n < 200) begin
      frame();
      n++;
    end
    check("split_exit_in_bound", n < 200, 1);
    check("split_exit_no_miss", bus.miss_out, 0);
    check("split_exit_cleared", bus.veggie_split_out[0], 0);

    found = 1'b0; n = 0;
    while (!found && n < 6000) begin
      for (int a = 0; a < NV; a++)
        for (int b = a + 1; b < NV; b++)
          if (!found && m_state[a] == 1 && m_state[b] == 1) begin
            cx = (m_x[a] > m_x[b]) ? m_x[a] : m_x[b];
            cy = (m_y[a] > m_y[b]) ? m_y[a] : m_y[b];
            if (cx < ((m_x[a] < m_x[b]) ? m_x[a] : m_x[b]) + 64 &&
                cy < ((m_y[a] < m_y[b]) ? m_y[a] : m_y[b]) + 64) begin
              found = 1'b1; kx = cx; ky = cy;
            end
          end
      if (found) begin
        k = 0;
        for (int i = 0; i < NV; i++)
          if (m_state[i] == 1 && kx >= m_x[i] && kx < m_x[i] + 64 &&
              ky >= m_y[i] && ky < m_y[i] + 64) k++;
        s_before = m_score;
        tick(1'b1);
        check("multi_hit_score", bus.score_out, 64'(s_before + k));
        check("multi_hit_pulses", $countones(bus.split_pulse_out), 64'(k));
        check("multi_hit_two_or_more", k >= 2, 1);
        tick(1'b0);
        kx = FAR_X; ky = FAR_Y;
      end else begin
        frame();
      end
      n++;
    end
    check("multi_hit_found", found, 1);

    n = 0;
    while (m_raw_miss < 255 && n < 12000) begin
      frame();
      n++;
    end
    check("miss_reach_255", m_raw_miss >= 255, 1);
    check("miss_at_255", bus.miss_out, 255);
    miss_mark = m_raw_miss;
    n = 0;
    while (m_raw_miss == miss_mark && n < 2000) begin
      frame();
      n++;
    end
    check("miss_one_more", m_raw_miss > miss_mark, 1);
    check("miss_saturated", bus.miss_out, 255);

    n = 0;
    while (bus.veggie_active_out == 0 && n < 500) begin
      frame();
      n++;
    end
    check("flying_before_reset", bus.veggie_active_out != 0, 1);
    rst = 1'b1;
    tick(1'b0);
    rst = 1'b0;
    check("midrst_score", bus.score_out, 0);
    check("midrst_miss", bus.miss_out, 0);
    check("midrst_active", bus.veggie_active_out, 0);
    check("midrst_y", bus.veggie_y_out, 0);
    for (int f = 1; f <= 120; f++) begin
      if (f == 60) check("restagger_slot0_idle", bus.veggie_active_out[0], 0);
      frame();
      if (f == 60) check("restagger_slot0_active", bus.veggie_active_out[0], 1);
      if (f == 119) check("restagger_slot1_idle", bus.veggie_active_out[1], 0);
      if (f == 120) check("restagger_slot1_active", bus.veggie_active_out[1], 1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
